// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// rr_pick searches from a rotating start index, wrapping at num rather than 2^width.
package axis_arb_pkg;

    typedef enum logic {IDLE, GRANT} state_t;

    localparam int unsigned DEF_ID_W = 2;
    localparam int unsigned MAX_SRC  = 16;

    // ptr < num and i < num, so a single conditional subtract is enough for the wrap
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input logic [4:0]  num);
        logic [4:0] idx;
        logic       found;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_SRC; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= num)
                idx = idx - num;
            if (!found && (5'(i) < num) && req[idx[3:0]]) begin
                rr_pick = idx[3:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry registered stream stage carrying data plus source id.
// can_load tells the producer a new beat may be written this cycle.
module axis_out_reg #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ID_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ID_W-1:0]   in_id,
    output logic [DATA_W-1:0] m_data,
    output logic [ID_W-1:0]   m_id,
    output logic              m_vld,
    input  logic              m_rdy,
    output logic              can_load
);

    assign can_load = !m_vld || m_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= '0;
            m_id   <= '0;
            m_vld  <= 1'b0;
        end else if (ld) begin
            m_data <= in_data;
            m_id   <= in_id;
            m_vld  <= 1'b1;
        end else if (m_rdy) begin
            m_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin merge of NUM_SRC valid/ready sample streams into one registered stream.
// Each grant lasts up to BURST_LEN beats; one IDLE cycle arbitrates between grants.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 3,
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned BURST_LEN = 2,
    parameter int unsigned ID_W      = DEF_ID_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*DATA_W-1:0] s_data,
    input  logic [NUM_SRC-1:0]        s_vld,
    output logic [NUM_SRC-1:0]        s_rdy,
    output logic [DATA_W-1:0]         m_data,
    output logic [ID_W-1:0]           m_id,
    output logic                      m_vld,
    input  logic                      m_rdy,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   nxt_ptr;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              can_load;
    logic              ld;
    logic              cur_vld;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        cur_vld  = 1'b0;
        sel_data = '0;
        s_rdy    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (grant_q == ID_W'(i)) begin
                cur_vld  = s_vld[i];
                sel_data = s_data[i*DATA_W +: DATA_W];
                s_rdy[i] = (state_q == GRANT) && can_load;
            end
        end
    end

    assign ld      = (state_q == GRANT) && cur_vld && can_load;
    assign busy    = (state_q == GRANT);
    assign nxt_ptr = (grant_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // A dropped valid releases at once, even under backpressure, so a source can never stall us
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|s_vld) begin
                    grant_d = ID_W'(rr_pick(16'(s_vld), 4'(ptr_q), 5'(NUM_SRC)));
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!cur_vld || (can_load && (cnt_q == CNT_W'(BURST_LEN - 1)))) begin
                    ptr_d   = nxt_ptr;
                    state_d = IDLE;
                end else if (can_load) begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    axis_out_reg #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) u_out (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld       (ld),
        .in_data  (sel_data),
        .in_id    (grant_q),
        .m_data   (m_data),
        .m_id     (m_id),
        .m_vld    (m_vld),
        .m_rdy    (m_rdy),
        .can_load (can_load)
    );

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: BURST_LEN=2 and BURST_LEN=1 instances share inputs.
module tb_axis_rr_arbiter;

    typedef struct {
        logic [1:0]  id;
        logic [23:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [71:0] s_data = '0;
    logic [2:0]  s_vld = '0;
    logic        m_rdy = 1'b0;

    logic [2:0]  s_rdy0, s_rdy1;
    logic [23:0] m_data0, m_data1;
    logic [1:0]  m_id0, m_id1;
    logic        m_vld0, m_vld1, busy0, busy1;

    axis_rr_arbiter #(.NUM_SRC(3), .DATA_W(24), .BURST_LEN(2), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy0),
        .m_data(m_data0), .m_id(m_id0), .m_vld(m_vld0), .m_rdy(m_rdy), .busy(busy0)
    );

    axis_rr_arbiter #(.NUM_SRC(3), .DATA_W(24), .BURST_LEN(1), .ID_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy1),
        .m_data(m_data1), .m_id(m_id1), .m_vld(m_vld1), .m_rdy(m_rdy), .busy(busy1)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t exp_q[$];
    int    seq[3];
    int    budget[3];
    logic [2:0]  req = '0;
    logic        rdy = 1'b0;
    logic        out_fire;
    logic [1:0]  out_id;
    logic [23:0] out_data;
    logic        out_vld;
    logic        out_busy;
    logic [2:0]  cur_srdy;

    function automatic logic [23:0] src_data(input int i, input int n);
        return 24'h123456 + 24'(i) * 24'h100000 + 24'(n) * 24'h000111;
    endfunction

    // Drive one cycle of source/sink stimulus and record accepted beats as expectations
    task automatic tick(input int sel);
        beat_t b;
        logic [2:0] v;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            s_data[i*24 +: 24] = src_data(i, seq[i]);
            v[i] = req[i] && (budget[i] != 0);
        end
        s_vld = v;
        m_rdy = rdy;
        #1;
        out_vld  = (sel == 0) ? m_vld0  : m_vld1;
        out_id   = (sel == 0) ? m_id0   : m_id1;
        out_data = (sel == 0) ? m_data0 : m_data1;
        out_busy = (sel == 0) ? busy0   : busy1;
        cur_srdy = (sel == 0) ? s_rdy0  : s_rdy1;
        out_fire = out_vld && m_rdy;
        for (int i = 0; i < 3; i++) begin
            if (s_vld[i] && cur_srdy[i]) begin
                b.id   = 2'(i);
                b.data = src_data(i, seq[i]);
                exp_q.push_back(b);
                seq[i]++;
                if (budget[i] > 0) budget[i]--;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        s_vld = '0;
        m_rdy = 1'b0;
        rdy   = 1'b0;
        req   = '0;
        for (int i = 0; i < 3; i++) begin
            seq[i]    = 0;
            budget[i] = -1;
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        beat_t b;
        for (int i = 0; i < 3; i++) begin
            seq[i] = 0; budget[i] = -1;
            s_data[i*24 +: 24] = src_data(i, 0);
        end
        exp_q.delete();
        s_vld = 3'b111; m_rdy = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (m_vld0 !== 1'b0) begin n_bad++; $display("FAIL reset_m_vld: got %b expected 0", m_vld0); end
        n_cmp++; if (m_data0 !== 24'h0) begin n_bad++; $display("FAIL reset_m_data: got %h expected 000000", m_data0); end
        n_cmp++; if (m_id0 !== 2'd0) begin n_bad++; $display("FAIL reset_m_id: got %0d expected 0", m_id0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        n_cmp++; if (s_rdy0 !== 3'b000) begin n_bad++; $display("FAIL reset_s_rdy: got %b expected 000", s_rdy0); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req = 3'b111; rdy = 1'b1;
        tick(0);
        n_cmp++; if (out_busy !== 1'b1) begin n_bad++; $display("FAIL rel_busy: got %b expected 1", out_busy); end
        n_cmp++; if (cur_srdy !== 3'b001) begin n_bad++; $display("FAIL rel_s_rdy: got %b expected 001", cur_srdy); end
        tick(0);
        n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL rel_m_vld: got %b expected 1", out_vld); end
        n_cmp++; if (out_id !== 2'd0) begin n_bad++; $display("FAIL rel_m_id: got %0d expected 0", out_id); end
        n_cmp++; if (out_data !== 24'h123456) begin n_bad++; $display("FAIL rel_m_data: got %h expected 123456", out_data); end
        if (exp_q.size() > 0) b = exp_q.pop_front();
    endtask

    task automatic test_contention();
        int exp_ids[8] = '{0, 0, 1, 1, 2, 2, 0, 0};
        int beats = 0;
        int gap = 0;
        beat_t b;
        reset_dut();
        req = 3'b111; rdy = 1'b1;
        for (int c = 0; c < 60 && beats < 8; c++) begin
            tick(0);
            if (out_fire) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL cont_sb: unexpected beat id %0d data %h, expected none", out_id, out_data);
                end else begin
                    b = exp_q.pop_front();
                    if (out_data !== b.data || out_id !== b.id) begin
                        n_bad++; $display("FAIL cont_sb: got %0d/%h expected %0d/%h", out_id, out_data, b.id, b.data);
                    end
                end
                n_cmp++; if (out_id !== 2'(exp_ids[beats])) begin n_bad++; $display("FAIL cont_id[%0d]: got %0d expected %0d", beats, out_id, exp_ids[beats]); end
                if (beats > 0) begin
                    n_cmp++; if (gap != ((beats % 2 == 0) ? 1 : 0)) begin n_bad++; $display("FAIL cont_gap[%0d]: got %0d expected %0d", beats, gap, (beats % 2 == 0) ? 1 : 0); end
                end
                beats++; gap = 0;
            end else if (beats > 0) begin
                gap++;
            end
        end
        n_cmp++; if (beats != 8) begin n_bad++; $display("FAIL cont_timeout: got %0d beats expected 8", beats); end
    endtask

    task automatic test_early_release();
        int exp_ids[7] = '{0, 0, 1, 2, 2, 0, 0};
        int exp_gap[7] = '{0, 0, 1, 2, 0, 1, 0};
        int beats = 0;
        int gap = 0;
        beat_t b;
        reset_dut();
        budget[1] = 1;
        req = 3'b111; rdy = 1'b1;
        for (int c = 0; c < 60 && beats < 7; c++) begin
            tick(0);
            if (out_fire) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL early_sb: unexpected beat id %0d, expected none", out_id);
                end else begin
                    b = exp_q.pop_front();
                    if (out_data !== b.data || out_id !== b.id) begin
                        n_bad++; $display("FAIL early_sb: got %0d/%h expected %0d/%h", out_id, out_data, b.id, b.data);
                    end
                end
                n_cmp++; if (out_id !== 2'(exp_ids[beats])) begin n_bad++; $display("FAIL early_id[%0d]: got %0d expected %0d", beats, out_id, exp_ids[beats]); end
                if (beats > 0) begin
                    n_cmp++; if (gap != exp_gap[beats]) begin n_bad++; $display("FAIL early_gap[%0d]: got %0d expected %0d", beats, gap, exp_gap[beats]); end
                end
                beats++; gap = 0;
            end else if (beats > 0) begin
                gap++;
            end
        end
        n_cmp++; if (beats != 7) begin n_bad++; $display("FAIL early_timeout: got %0d beats expected 7", beats); end
    endtask

    task automatic test_backpressure();
        int exp_ids[4] = '{0, 0, 1, 1};
        int exp_gap[4] = '{0, 0, 1, 0};
        int beats = 0;
        int gap = 0;
        int c;
        beat_t b;
        reset_dut();
        req = 3'b111; rdy = 1'b1;
        for (c = 0; c < 10; c++) begin
            tick(0);
            if (cur_srdy != 3'b000) break;
        end
        n_cmp++; if (c >= 10) begin n_bad++; $display("FAIL bp_start_timeout: got no grant expected grant within 10 cycles"); end
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(0);
            n_cmp++; if (out_vld !== 1'b1) begin n_bad++; $display("FAIL bp_m_vld[%0d]: got %b expected 1", k, out_vld); end
            n_cmp++; if (out_data !== 24'h123456) begin n_bad++; $display("FAIL bp_m_data[%0d]: got %h expected 123456", k, out_data); end
            n_cmp++; if (out_id !== 2'd0) begin n_bad++; $display("FAIL bp_m_id[%0d]: got %0d expected 0", k, out_id); end
            n_cmp++; if (cur_srdy !== 3'b000) begin n_bad++; $display("FAIL bp_s_rdy[%0d]: got %b expected 000", k, cur_srdy); end
        end
        rdy = 1'b1;
        for (int k = 0; k < 30 && beats < 4; k++) begin
            tick(0);
            if (out_fire) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL bp_sb: unexpected beat id %0d, expected none", out_id);
                end else begin
                    b = exp_q.pop_front();
                    if (out_data !== b.data || out_id !== b.id) begin
                        n_bad++; $display("FAIL bp_sb: got %0d/%h expected %0d/%h", out_id, out_data, b.id, b.data);
                    end
                end
                n_cmp++; if (out_id !== 2'(exp_ids[beats])) begin n_bad++; $display("FAIL bp_id[%0d]: got %0d expected %0d", beats, out_id, exp_ids[beats]); end
                if (beats > 0) begin
                    n_cmp++; if (gap != exp_gap[beats]) begin n_bad++; $display("FAIL bp_gap[%0d]: got %0d expected %0d", beats, gap, exp_gap[beats]); end
                end
                beats++; gap = 0;
            end else if (beats > 0) begin
                gap++;
            end
        end
        n_cmp++; if (beats != 4) begin n_bad++; $display("FAIL bp_timeout: got %0d beats expected 4", beats); end
    endtask

    task automatic test_single_requester();
        int beats = 0;
        int gap = 0;
        beat_t b;
        reset_dut();
        req = 3'b100; rdy = 1'b1;
        for (int c = 0; c < 60 && beats < 10; c++) begin
            tick(1);
            if (out_fire) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL single_sb: unexpected beat id %0d, expected none", out_id);
                end else begin
                    b = exp_q.pop_front();
                    if (out_data !== b.data) begin
                        n_bad++; $display("FAIL single_sb: got %h expected %h", out_data, b.data);
                    end
                end
                n_cmp++; if (out_id !== 2'd2) begin n_bad++; $display("FAIL single_id[%0d]: got %0d expected 2", beats, out_id); end
                if (beats > 0) begin
                    n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL single_gap[%0d]: got %0d expected 1", beats, gap); end
                end
                beats++; gap = 0;
            end else if (beats > 0) begin
                gap++;
            end
        end
        n_cmp++; if (beats != 10) begin n_bad++; $display("FAIL single_timeout: got %0d beats expected 10", beats); end
    endtask

    task automatic test_mid_reset();
        int exp_ids[3] = '{0, 0, 1};
        int beats = 0;
        int c;
        logic hit = 1'b0;
        beat_t b;
        reset_dut();
        req = 3'b111; rdy = 1'b1;
        for (c = 0; c < 40; c++) begin
            tick(0);
            if (out_vld && out_id == 2'd1) begin
                hit = 1'b1;
                break;
            end
            if (out_fire && exp_q.size() > 0) b = exp_q.pop_front();
        end
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL mid_start_timeout: got no src1 beat expected one within 40 cycles"); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (m_vld0 !== 1'b0) begin n_bad++; $display("FAIL mid_m_vld: got %b expected 0", m_vld0); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", busy0); end
        n_cmp++; if (s_rdy0 !== 3'b000) begin n_bad++; $display("FAIL mid_s_rdy: got %b expected 000", s_rdy0); end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (c = 0; c < 30 && beats < 3; c++) begin
            tick(0);
            if (out_fire) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL mid_stale: unexpected beat id %0d data %h, expected none", out_id, out_data);
                end else begin
                    b = exp_q.pop_front();
                    if (out_data !== b.data || out_id !== b.id) begin
                        n_bad++; $display("FAIL mid_sb: got %0d/%h expected %0d/%h", out_id, out_data, b.id, b.data);
                    end
                end
                n_cmp++; if (out_id !== 2'(exp_ids[beats])) begin n_bad++; $display("FAIL mid_id[%0d]: got %0d expected %0d", beats, out_id, exp_ids[beats]); end
                beats++;
            end
        end
        n_cmp++; if (beats != 3) begin n_bad++; $display("FAIL mid_timeout: got %0d beats expected 3", beats); end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_early_release();
        test_backpressure();
        test_single_requester();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
